// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the instruction memory write port
//
// Accepts frames of: 0xA5, 4-byte LE byte address, 2-byte LE word count N,
// 4*N LE data bytes, 1 XOR checksum byte over the data bytes. Each assembled
// word is written to the instruction memory with a one-cycle strobe.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_data      input byte stream; s_ready is the accept handshake
//   mem_we              one-cycle word write strobe
//   mem_waddr/mem_wdata registered word address and data (hold when idle)
//   busy                frame in progress
//   done                one-cycle pulse on a frame with a good checksum
//   error               sticky error, cleared when the next header is accepted
module imem_loader #(
  parameter int DEPTH = 1000,
  parameter int AW    = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, WRITE, CSUM} state_t;

  state_t          state, next_state;
  logic [1:0]      bcnt;
  logic [31:0]     addr;
  logic [15:0]     count;
  logic [15:0]     remaining;
  logic [AW-1:0]   word_addr;
  logic [31:0]     shreg;
  logic [7:0]      csum;

  logic            take;
  logic            hdr_ok;
  logic            count_last;
  logic            bad_frame;
  logic            err_set;
  logic            done_set;
  logic [15:0]     n_full;
  logic [32:0]     span;
  logic [31:0]     word_next;

  assign s_ready = (state != WRITE);
  assign busy    = (state != IDLE);
  assign mem_we  = (state == WRITE);
  assign take    = s_valid && s_ready;

  // Count bytes arrive low byte first; n_full is the complete N while its
  // high byte is on s_data, so the frame checks can resolve in that cycle.
  assign n_full     = {s_data, count[15:8]};
  // 33-bit sum so a huge address plus count cannot wrap into range.
  assign span       = 33'(addr[31:2]) + 33'(n_full);
  assign count_last = (state == COUNT) && take && bcnt[0];
  assign bad_frame  = (addr[1:0] != 2'b00) || (span > 33'(DEPTH));
  assign word_next  = {s_data, shreg[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    hdr_ok     = 1'b0;
    err_set    = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (take && s_data == 8'hA5) begin
          hdr_ok     = 1'b1;
          next_state = ADDR;
        end
      end
      ADDR: begin
        if (take && bcnt == 2'd3) next_state = COUNT;
      end
      COUNT: begin
        if (count_last) begin
          if (bad_frame) begin
            err_set    = 1'b1;
            next_state = IDLE;
          end else if (n_full == 16'd0) begin
            next_state = CSUM;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (take && bcnt == 2'd3) next_state = WRITE;
      end
      WRITE: begin
        // remaining still holds the pre-decrement count here
        next_state = (remaining != 16'd1) ? DATA : CSUM;
      end
      CSUM: begin
        if (take) begin
          if (s_data == csum) done_set = 1'b1;
          else                err_set  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt      <= 2'd0;
      addr      <= 32'd0;
      count     <= 16'd0;
      remaining <= 16'd0;
      word_addr <= '0;
      shreg     <= 32'd0;
      csum      <= 8'd0;
      mem_waddr <= '0;
      mem_wdata <= 32'd0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= done_set;
      if (hdr_ok)       error <= 1'b0;
      else if (err_set) error <= 1'b1;

      if (hdr_ok) begin
        bcnt <= 2'd0;
        csum <= 8'd0;
      end

      if (take && state == ADDR) begin
        addr <= {s_data, addr[31:8]};
        bcnt <= bcnt + 2'd1;
      end

      if (take && state == COUNT) begin
        count <= {s_data, count[15:8]};
        bcnt  <= bcnt[0] ? 2'd0 : 2'd1;
      end

      if (count_last) begin
        remaining <= n_full;
        word_addr <= addr[AW+1:2];
      end

      if (take && state == DATA) begin
        shreg <= word_next;
        csum  <= csum ^ s_data;
        bcnt  <= bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          mem_waddr <= word_addr;
          mem_wdata <= word_next;
        end
      end

      if (state == WRITE) begin
        word_addr <= word_addr + AW'(1);
        remaining <= remaining - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

  localparam int DEPTH = 1000;
  localparam int AW    = 30;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int gap_max = 0;

  logic [31:0] wq[$];
  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        got_a.push_back(32'(mem_waddr));
        got_d.push_back(mem_wdata);
        chk("ready_on_we", s_ready, 0);
      end
      if (done) done_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (t >= 16) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  // Reference: a frame is accepted only if aligned and in range; then each
  // word k goes to (a>>2)+k, and done iff the sent checksum equals the XOR
  // of all data bytes.
  task automatic run_frame(input string tag, input logic [31:0] a, input logic [15:0] n,
                           input bit force_cs, input logic [7:0] cs_val);
    bit          ok;
    logic [7:0]  x;
    logic [7:0]  sent;
    bit          exp_done;
    int          nwr;
    logic [31:0] w;
    got_a.delete();
    got_d.delete();
    done_cnt = 0;
    ok = (a[1:0] == 2'b00) && ((longint'(a >> 2) + longint'(n)) <= longint'(DEPTH));
    send_byte(8'hA5);
    @(negedge clk);
    chk({tag, "_hdr_err_clr"}, error, 0);
    chk({tag, "_hdr_busy"}, busy, 1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    x = 8'h00;
    exp_done = 1'b0;
    if (ok) begin
      for (int k = 0; k < int'(n); k++) begin
        w = wq[k];
        for (int j = 0; j < 4; j++) begin
          send_byte(w[8*j +: 8]);
          x ^= w[8*j +: 8];
        end
        @(negedge clk);
        chk({tag, "_we_lat"}, mem_we, 1);
      end
      sent = force_cs ? cs_val : x;
      send_byte(sent);
      exp_done = (sent == x);
    end
    repeat (3) @(negedge clk);
    nwr = ok ? int'(n) : 0;
    chk({tag, "_nwrites"}, got_a.size(), nwr);
    for (int k = 0; k < nwr && k < got_a.size(); k++) begin
      chk({tag, "_waddr"}, got_a[k], (a >> 2) + k);
      chk({tag, "_wdata"}, got_d[k], wq[k]);
    end
    chk({tag, "_done"}, done_cnt, exp_done ? 1 : 0);
    chk({tag, "_error"}, error, exp_done ? 0 : 1);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [15:0] n;
    int mode;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    wq = '{32'h00520663};
    run_frame("single", 32'h8, 16'd1, 1'b0, 8'h00);

    gap_max = 3;
    wq = '{32'h00128293, 32'hFF9FF16F, 32'h40520333};
    run_frame("multi", 32'h0C, 16'd3, 1'b0, 8'h00);

    wq = '{32'h11223344};
    run_frame("unaligned", 32'h6, 16'd1, 1'b0, 8'h00);
    wq = '{32'h11223344, 32'h55667788};
    run_frame("range_over", (DEPTH-1)*4, 16'd2, 1'b0, 8'h00);
    run_frame("range_edge", (DEPTH-1)*4, 16'd1, 1'b0, 8'h00);

    wq = '{32'h00520663};
    run_frame("bad_cs", 32'h8, 16'd1, 1'b1, 8'h00);
    wq = '{32'hDEADBEEF, 32'h0BADF00D};
    run_frame("after_bad", 32'h20, 16'd2, 1'b0, 8'h00);

    // reset with a partial word in flight
    got_a.delete();
    send_byte(8'hA5);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h57);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_ready", s_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_waddr", mem_waddr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_nowrite", got_a.size(), 0);

    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    chk("garbage_busy", busy, 0);
    wq = '{32'hCAFEF00D};
    run_frame("post_garbage", 32'h100, 16'd1, 1'b0, 8'h00);

    run_frame("empty", 32'h0, 16'd0, 1'b0, 8'h00);

    for (int r = 0; r < 20; r++) begin
      mode = $urandom_range(0, 9);
      n = 16'($urandom_range(1, 4));
      a = {20'd0, 10'($urandom_range(0, DEPTH - 5)), 2'b00};
      if (mode == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (mode == 1) a = 32'($urandom_range(DEPTH - 3, DEPTH + 50)) << 2;
      if (mode == 2) a = 32'hFFFF_FFF0;
      wq.delete();
      for (int k = 0; k < 4; k++) wq.push_back($urandom);
      gap_max = $urandom_range(0, 3);
      run_frame("rand", a, n, ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
